// File: rtl/active_list.sv
// In-order active list (reorder buffer): allocate at tail, complete on writeback,
// retire from head, and roll back younger entries one per cycle after a mispredict.
// Optional statistics counters are enabled with `define ACTIVE_LIST_STATS_EN.
module active_list #(
  parameter int DEPTH      = 32,
  parameter int ID_WIDTH   = 5,
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alloc_valid,
  input  logic                  i_alloc_uses_rw,
  input  logic [AREG_WIDTH-1:0] i_alloc_arch,
  input  logic [PREG_WIDTH-1:0] i_alloc_preg_new,
  input  logic [PREG_WIDTH-1:0] i_alloc_preg_old,
  output logic [ID_WIDTH-1:0]   o_alloc_id,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic                  i_wb_valid,
  input  logic [ID_WIDTH-1:0]   i_wb_id,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_commit_valid,
  output logic                  o_commit_uses_rw,
  output logic [PREG_WIDTH-1:0] o_commit_preg,
  output logic [DATA_WIDTH-1:0] o_commit_data,
  output logic [PREG_WIDTH-1:0] o_commit_free_preg,
  input  logic                  i_flush_req,
  input  logic [ID_WIDTH-1:0]   i_flush_id,
  output logic                  o_flush_in_progress,
  output logic                  o_rb_valid,
  output logic [AREG_WIDTH-1:0] o_rb_arch,
  output logic [PREG_WIDTH-1:0] o_rb_preg_old,
  output logic [PREG_WIDTH-1:0] o_rb_preg_new
`ifdef ACTIVE_LIST_STATS_EN
  ,
  output logic [31:0]           o_stat_commits,
  output logic [31:0]           o_stat_rollbacks
`endif
);

  typedef enum logic {S_IDLE, S_ROLLBACK} state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_head;
  logic [ID_WIDTH-1:0]   r_tail;
  logic [ID_WIDTH-1:0]   r_flushId;
  logic [ID_WIDTH:0]     r_count;

  logic                  r_valid   [DEPTH];
  logic                  r_done    [DEPTH];
  logic                  r_usesRw  [DEPTH];
  logic [AREG_WIDTH-1:0] r_arch    [DEPTH];
  logic [PREG_WIDTH-1:0] r_pregNew [DEPTH];
  logic [PREG_WIDTH-1:0] r_pregOld [DEPTH];
  logic [DATA_WIDTH-1:0] r_data    [DEPTH];

  logic [ID_WIDTH-1:0]   w_tailM1;
  logic                  w_allocFire;
  logic                  w_commitFire;
  logic                  w_rbFire;
  logic                  w_wbFire;
  logic                  w_flushAccept;

  assign w_tailM1      = r_tail - ID_WIDTH'(1);
  assign w_allocFire   = i_alloc_valid && !o_full && (r_state == S_IDLE);
  assign w_commitFire  = r_valid[r_head] && r_done[r_head] && (r_state == S_IDLE);
  // Rollback stops once the youngest remaining entry is the surviving branch.
  assign w_rbFire      = (r_state == S_ROLLBACK) && (w_tailM1 != r_flushId);
  assign w_wbFire      = i_wb_valid && r_valid[i_wb_id];
  assign w_flushAccept = i_flush_req && (r_state == S_IDLE) && r_valid[i_flush_id];

  assign o_alloc_id          = r_tail;
  assign o_full              = (r_count == (ID_WIDTH+1)'(DEPTH));
  assign o_empty             = (r_count == '0);
  assign o_flush_in_progress = (r_state == S_ROLLBACK);

  assign o_commit_valid     = w_commitFire;
  assign o_commit_uses_rw   = w_commitFire ? r_usesRw[r_head]  : 1'b0;
  assign o_commit_preg      = w_commitFire ? r_pregNew[r_head] : '0;
  assign o_commit_data      = w_commitFire ? r_data[r_head]    : '0;
  assign o_commit_free_preg = w_commitFire ? r_pregOld[r_head] : '0;

  assign o_rb_valid    = w_rbFire;
  assign o_rb_arch     = w_rbFire ? r_arch[w_tailM1]    : '0;
  assign o_rb_preg_old = w_rbFire ? r_pregOld[w_tailM1] : '0;
  assign o_rb_preg_new = w_rbFire ? r_pregNew[w_tailM1] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_flushId <= '0;
      r_count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
    end else begin
      if (w_wbFire) begin
        r_done[i_wb_id] <= 1'b1;
      end
      if (w_allocFire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
      end
      if (w_commitFire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + ID_WIDTH'(1);
      end
      if (w_rbFire) begin
        r_valid[w_tailM1] <= 1'b0;
        r_done[w_tailM1]  <= 1'b0;
      end

      if (w_allocFire) begin
        r_tail <= r_tail + ID_WIDTH'(1);
      end else if (w_rbFire) begin
        r_tail <= w_tailM1;
      end

      r_count <= r_count + (ID_WIDTH+1)'(w_allocFire)
                         - (ID_WIDTH+1)'(w_commitFire)
                         - (ID_WIDTH+1)'(w_rbFire);

      case (r_state)
        S_IDLE: begin
          if (w_flushAccept) begin
            r_state   <= S_ROLLBACK;
            r_flushId <= i_flush_id;
          end
        end
        S_ROLLBACK: begin
          if (!w_rbFire) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through entries marked valid.
  always_ff @(posedge i_clk) begin
    if (w_allocFire) begin
      r_usesRw[r_tail]  <= i_alloc_uses_rw;
      r_arch[r_tail]    <= i_alloc_arch;
      r_pregNew[r_tail] <= i_alloc_preg_new;
      r_pregOld[r_tail] <= i_alloc_preg_old;
    end
    if (w_wbFire) begin
      r_data[i_wb_id] <= i_wb_data;
    end
  end

`ifdef ACTIVE_LIST_STATS_EN
  logic [31:0] r_statCommits;
  logic [31:0] r_statRollbacks;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_statCommits   <= '0;
      r_statRollbacks <= '0;
    end else begin
      if (w_commitFire && (r_statCommits != '1)) begin
        r_statCommits <= r_statCommits + 32'd1;
      end
      if (w_rbFire && (r_statRollbacks != '1)) begin
        r_statRollbacks <= r_statRollbacks + 32'd1;
      end
    end
  end

  assign o_stat_commits   = r_statCommits;
  assign o_stat_rollbacks = r_statRollbacks;
`endif

endmodule

// File: tb/tb_active_list.sv
// Bench for active_list: directed scenarios followed by random traffic, all checked
// against a queue-based model of the in-order window.
module tb_active_list;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        allocValid, allocUsesRw;
  logic [4:0]  allocArch;
  logic [5:0]  allocPregNew, allocPregOld;
  logic [4:0]  allocId;
  logic        full, empty;
  logic        wbValid;
  logic [4:0]  wbId;
  logic [31:0] wbData;
  logic        commitValid, commitUsesRw;
  logic [5:0]  commitPreg, commitFreePreg;
  logic [31:0] commitData;
  logic        flushReq;
  logic [4:0]  flushId;
  logic        flushInProgress, rbValid;
  logic [4:0]  rbArch;
  logic [5:0]  rbPregOld, rbPregNew;
`ifdef ACTIVE_LIST_STATS_EN
  logic [31:0] statCommits, statRollbacks;
`endif

  active_list dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alloc_valid(allocValid), .i_alloc_uses_rw(allocUsesRw), .i_alloc_arch(allocArch),
    .i_alloc_preg_new(allocPregNew), .i_alloc_preg_old(allocPregOld),
    .o_alloc_id(allocId), .o_full(full), .o_empty(empty),
    .i_wb_valid(wbValid), .i_wb_id(wbId), .i_wb_data(wbData),
    .o_commit_valid(commitValid), .o_commit_uses_rw(commitUsesRw), .o_commit_preg(commitPreg),
    .o_commit_data(commitData), .o_commit_free_preg(commitFreePreg),
    .i_flush_req(flushReq), .i_flush_id(flushId),
    .o_flush_in_progress(flushInProgress), .o_rb_valid(rbValid), .o_rb_arch(rbArch),
    .o_rb_preg_old(rbPregOld), .o_rb_preg_new(rbPregNew)
`ifdef ACTIVE_LIST_STATS_EN
    , .o_stat_commits(statCommits), .o_stat_rollbacks(statRollbacks)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: the window is a queue ordered oldest to youngest.
  typedef struct {
    logic [4:0]  id;
    logic        usesRw;
    logic [4:0]  arch;
    logic [5:0]  pregNew;
    logic [5:0]  pregOld;
    logic        done;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic [4:0]  nextId;
  bit          flushing;
  logic [4:0]  flushTarget;
  int unsigned mStatCommits, mStatRollbacks;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit inQueue(input logic [4:0] id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit modelCommit();
    return !flushing && (q.size() > 0) && q[0].done;
  endfunction

  function automatic bit modelRb();
    return flushing && (q.size() > 0) && (q[$].id != flushTarget);
  endfunction

  task automatic checkOutput();
    bit c, r;
    c = modelCommit();
    r = modelRb();
    checkVal("alloc_id", allocId, nextId);
    checkVal("full", full, q.size() == 32);
    checkVal("empty", empty, q.size() == 0);
    checkVal("flush_in_progress", flushInProgress, flushing);
    checkVal("commit_valid", commitValid, c);
    if (c) begin
      checkVal("commit_uses_rw", commitUsesRw, q[0].usesRw);
      checkVal("commit_preg", commitPreg, q[0].pregNew);
      checkVal("commit_data", commitData, q[0].data);
      checkVal("commit_free_preg", commitFreePreg, q[0].pregOld);
    end
    checkVal("rb_valid", rbValid, r);
    if (r) begin
      checkVal("rb_arch", rbArch, q[$].arch);
      checkVal("rb_preg_old", rbPregOld, q[$].pregOld);
      checkVal("rb_preg_new", rbPregNew, q[$].pregNew);
    end
`ifdef ACTIVE_LIST_STATS_EN
    checkVal("stat_commits", statCommits, mStatCommits);
    checkVal("stat_rollbacks", statRollbacks, mStatRollbacks);
`endif
  endtask

  task automatic modelReset();
    q.delete();
    nextId         = '0;
    flushing       = 1'b0;
    flushTarget    = '0;
    mStatCommits   = 0;
    mStatRollbacks = 0;
  endtask

  task automatic updateModel();
    bit c, r, a, f;
    entry_t e;
    if (!rst_n) begin
      modelReset();
      return;
    end
    c = modelCommit();
    r = modelRb();
    a = allocValid && (q.size() < 32) && !flushing;
    f = flushReq && !flushing && inQueue(flushId);
    if (wbValid) begin
      foreach (q[i]) if (q[i].id == wbId) begin
        q[i].done = 1'b1;
        q[i].data = wbData;
      end
    end
    if (c) begin
      void'(q.pop_front());
      if (mStatCommits != 32'hFFFF_FFFF) mStatCommits++;
    end
    if (r) begin
      void'(q.pop_back());
      nextId = nextId - 5'd1;
      if (mStatRollbacks != 32'hFFFF_FFFF) mStatRollbacks++;
    end else if (flushing) begin
      flushing = 1'b0;
    end
    if (a) begin
      e.id = nextId; e.usesRw = allocUsesRw; e.arch = allocArch;
      e.pregNew = allocPregNew; e.pregOld = allocPregOld; e.done = 1'b0; e.data = '0;
      q.push_back(e);
      nextId = nextId + 5'd1;
    end
    if (f) begin
      flushing    = 1'b1;
      flushTarget = flushId;
    end
  endtask

  // One cycle: inputs are already driven; check mid-cycle, then advance model and DUT.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic setIdle();
    allocValid = 0; allocUsesRw = 0; allocArch = '0; allocPregNew = '0; allocPregOld = '0;
    wbValid = 0; wbId = '0; wbData = '0; flushReq = 0; flushId = '0;
  endtask

  task automatic setAlloc(input logic [4:0] arch, input logic [5:0] pn, input logic [5:0] po);
    setIdle();
    allocValid = 1; allocUsesRw = 1; allocArch = arch; allocPregNew = pn; allocPregOld = po;
  endtask

  task automatic setWb(input logic [4:0] id, input logic [31:0] d);
    setIdle();
    wbValid = 1; wbId = id; wbData = d;
  endtask

  task automatic doReset();
    setIdle();
    rst_n = 0;
    applyStimulus();
    rst_n = 1;
  endtask

  initial begin
    setIdle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst_n = 1;
    checkVal("reset_empty", empty, 1);
    checkVal("reset_alloc_id", allocId, 0);
    checkVal("reset_commit_valid", commitValid, 0);
    checkVal("reset_fip", flushInProgress, 0);

    // Three allocations, out-of-order writebacks, in-order commits.
    for (int i = 0; i < 3; i++) begin
      setAlloc(5'(i + 1), 6'(33 + i), 6'(i + 1));
      applyStimulus();
    end
    setIdle();
    checkVal("alloc3_id", allocId, 3);
    checkVal("alloc3_empty", empty, 0);
    setWb(5'd1, 32'h55); applyStimulus();
    setWb(5'd0, 32'hAA); applyStimulus();
    setIdle();
    checkVal("c0_valid", commitValid, 1);
    checkVal("c0_preg", commitPreg, 33);
    checkVal("c0_data", commitData, 32'hAA);
    checkVal("c0_free", commitFreePreg, 1);
    applyStimulus();
    checkVal("c1_preg", commitPreg, 34);
    checkVal("c1_data", commitData, 32'h55);
    checkVal("c1_free", commitFreePreg, 2);
    applyStimulus();
    checkVal("c2_hold", commitValid, 0);
    applyStimulus();

    // Fill to 32, overflow attempt, then drain and wrap.
    doReset();
    for (int i = 0; i < 32; i++) begin
      setAlloc(5'(i), 6'(i + 32), 6'(i));
      applyStimulus();
    end
    checkVal("full_set", full, 1);
    applyStimulus();
    checkVal("overflow_ignored_id", allocId, 0);
    checkVal("overflow_still_full", full, 1);
    for (int i = 0; i < 32; i++) begin
      setWb(5'(i), 32'h1000 + 32'(i));
      applyStimulus();
    end
    setIdle();
    repeat (3) applyStimulus();
    checkVal("drain_empty", empty, 1);
    checkVal("drain_wrap_id", allocId, 0);

    // Alloc and commit in the same cycle while full.
    for (int i = 0; i < 32; i++) begin
      setAlloc(5'(i), 6'(i), 6'(63 - i));
      applyStimulus();
    end
    setWb(5'd0, 32'hBEEF); applyStimulus();
    setAlloc(5'd7, 6'd7, 6'd8);
    checkVal("fullcommit_cv", commitValid, 1);
    applyStimulus();
    checkVal("fullcommit_rejected_full", full, 0);
    checkVal("fullcommit_rejected_id", allocId, 0);
    applyStimulus();
    checkVal("fullcommit_accepted_id", allocId, 1);
    checkVal("fullcommit_full_again", full, 1);

    // Flush to id 1 with ids 0..4 outstanding.
    doReset();
    for (int i = 0; i < 5; i++) begin
      setAlloc(5'(10 + i), 6'(40 + i), 6'(20 + i));
      applyStimulus();
    end
    setIdle(); flushReq = 1; flushId = 5'd1;
    applyStimulus();
    setIdle();
    checkVal("rb_first_fip", flushInProgress, 1);
    checkVal("rb_first_valid", rbValid, 1);
    checkVal("rb_first_arch", rbArch, 14);
    checkVal("rb_first_old", rbPregOld, 24);
    checkVal("rb_first_new", rbPregNew, 44);
    repeat (4) applyStimulus();
    checkVal("rb_done_fip", flushInProgress, 0);
    checkVal("rb_done_id", allocId, 2);

    // Flush of the youngest entry: one rollback cycle with nothing presented.
    setIdle(); flushReq = 1; flushId = 5'd1;
    applyStimulus();
    setIdle();
    checkVal("youngest_fip", flushInProgress, 1);
    checkVal("youngest_rb", rbValid, 0);
    applyStimulus();
    checkVal("youngest_end", flushInProgress, 0);

    // Reset in the middle of a rollback.
    doReset();
    for (int i = 0; i < 5; i++) begin
      setAlloc(5'(i), 6'(i), 6'(i));
      applyStimulus();
    end
    setIdle(); flushReq = 1; flushId = 5'd0;
    applyStimulus();
    setIdle();
    applyStimulus();
    rst_n = 0;
    applyStimulus();
    rst_n = 1;
    checkVal("midrb_fip", flushInProgress, 0);
    checkVal("midrb_rb", rbValid, 0);
    checkVal("midrb_empty", empty, 1);
    checkVal("midrb_id", allocId, 0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      setIdle();
      allocValid   = ($urandom_range(0, 9) < 6);
      allocUsesRw  = 1'($urandom);
      allocArch    = 5'($urandom);
      allocPregNew = 6'($urandom);
      allocPregOld = 6'($urandom);
      wbValid      = ($urandom_range(0, 9) < 6);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wbId = q[$urandom_range(0, q.size() - 1)].id;
      else
        wbId = 5'($urandom);
      wbData   = $urandom;
      flushReq = ($urandom_range(0, 19) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        flushId = q[$urandom_range(0, q.size() - 1)].id;
      else
        flushId = 5'($urandom);
      applyStimulus();
    end
    setIdle();
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/active_list.md
Name: active_list

Overview:
- In-order reorder buffer (active list) of the out-of-order MIPS core, between rename/issue and register-file commit.
- Allocates one entry per renamed instruction in program order and hands back an instruction ID.
- Marks entries complete on writeback and retires them in order; commit updates architectural state and frees the superseded physical register.
- On a mispredict flush, rolls back younger entries one per cycle so the map table and free list can be restored.

Parameters:
- DEPTH, 32, number of entries; power of two.
- ID_WIDTH, 5, log2(DEPTH); width of instruction IDs.
- PREG_WIDTH, 6, physical register index width (64 physical regs).
- AREG_WIDTH, 5, architectural register index width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid  in  1  rename stage presents an instruction this cycle
- alloc_uses_rw  in  1  instruction writes a destination register
- alloc_arch  in  AREG_WIDTH  architectural destination
- alloc_preg_new  in  PREG_WIDTH  newly mapped physical destination
- alloc_preg_old  in  PREG_WIDTH  previous mapping of alloc_arch
- alloc_id  out  ID_WIDTH  ID given to the allocating instruction (= tail)
- full  out  1  no free entry; rename must stall
- empty  out  1  no valid entry
- wb_valid  in  1  an instruction completed
- wb_id  in  ID_WIDTH  ID of the completed instruction
- wb_data  in  DATA_WIDTH  result value
- commit_valid  out  1  head entry retires this cycle
- commit_uses_rw  out  1  retiring entry writes a register
- commit_preg  out  PREG_WIDTH  physical register to write
- commit_data  out  DATA_WIDTH  value to write
- commit_free_preg  out  PREG_WIDTH  old mapping returned to the free list
- flush_req  in  1  one-cycle pulse: branch flush_id mispredicted
- flush_id  in  ID_WIDTH  surviving youngest entry
- flush_in_progress  out  1  rollback active; front end stalls
- rb_valid  out  1  one rollback entry presented
- rb_arch  out  AREG_WIDTH  map-table entry to restore
- rb_preg_old  out  PREG_WIDTH  mapping to restore
- rb_preg_new  out  PREG_WIDTH  physical register returned to the free list

Behaviour:
- State per entry: valid, done, uses_rw, arch, preg_new, preg_old, data. Pointers head and tail, plus count (0..DEPTH).
- full = (count == DEPTH); empty = (count == 0); alloc_id = tail. All are derived from registered state.
- Reset (rst_n=0 at a clk edge) clears all valid/done bits, head, tail, count and flush state. All outputs then read 0, except empty=1 and alloc_id=0. Reset mid-rollback abandons the rollback.

Allocate:
- Occurs when alloc_valid && !full && !flush_in_progress.
- Writes the entry at tail with valid=1, done=0; tail increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Allocation while full, or while flush_in_progress, is ignored.

Writeback:
- When wb_valid and entry wb_id is valid: set done=1 and store wb_data.
- Writeback to an invalid entry is ignored.

Commit:
- Combinational outputs, one per cycle: commit_valid = head valid && head done && !flush_in_progress.
- Fields come from the head entry. At the clock edge, the head is cleared and head increments with wrap.
- Writeback to the head in cycle N gives commit no earlier than N+1.
- Alloc and commit may occur in the same cycle: count is unchanged. When full, a same-cycle commit does not admit the allocation; it is accepted the next cycle.

Flush:
- flush_req is honoured only if flush_id names a valid entry; otherwise it is ignored.
- The next cycle enters ROLLBACK with flush_in_progress=1.
- Each ROLLBACK cycle: the entry at tail-1 is presented on rb_* with rb_valid=1. At the edge it is invalidated, tail decrements (wrap 0 -> DEPTH-1), and count decrements.
- ROLLBACK ends after the entry just above flush_id is removed. flush_in_progress falls the following cycle.
- If flush_id is already the youngest, there is a single cycle of flush_in_progress=1 with rb_valid=0.
- Writebacks are still accepted during rollback. A writeback to a removed entry is dropped.
- flush_req during ROLLBACK is ignored.
- States: IDLE -> ROLLBACK on an accepted flush_req; ROLLBACK -> IDLE when tail-1 == flush_id.

Optional Feature:
- ACTIVE_LIST_STATS_EN: adds outputs stat_commits (32 bits) and stat_rollbacks (32 bits).
  - stat_commits increments on each commit_valid cycle; stat_rollbacks increments on each rb_valid cycle.
  - Both are cleared by reset and saturate at all-ones.
- Without the macro, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then allocate 3 instructions (arch 1,2,3; preg_new 33,34,35; preg_old 1,2,3) -> alloc_id 0,1,2; count 3; empty=0; no commit.
- Writeback id1 (0x55) then id0 (0xAA) -> commit id0 (preg 33, data 0xAA, free 1), then id1 (preg 34, data 0x55, free 2) on consecutive cycles; id2 holds.
- Allocate 32 with no writebacks -> full=1; a 33rd alloc_valid is ignored. Writeback all and drain -> 32 in-order commits; head and tail wrap to 0; empty=1.
- With ids 0..4 allocated, flush_req, flush_id=1 -> rb_valid for ids 4,3,2 (rb_arch/preg_old/preg_new from allocation) on 3 cycles; flush_in_progress high 4 cycles; next alloc_id=2.
- Alloc and commit in the same cycle when full -> alloc rejected, count 31; accepted next cycle with alloc_id equal to the old head index.
- Assert rst_n low mid-rollback -> next cycle flush_in_progress=0, rb_valid=0, count 0, empty=1.
